// File: rtl/uart_cmd_pkg.sv
// Shared state encoding, command codes and the command legality rule for the
// UART command front end.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    S_HUNT,
    S_CMD,
    S_LENH,
    S_LENL,
    S_CHK,
    S_ISSUE,
    S_RUN,
    S_REL,
    S_WAIT
  } state_t;

  localparam logic [7:0] CMD_NONE = 8'h00;
  localparam logic [7:0] CMD_RX   = 8'h01;
  localparam logic [7:0] CMD_INIT = 8'h02;
  localparam logic [7:0] CMD_RD   = 8'h03;
  localparam logic [7:0] CMD_WR   = 8'h04;

  // Busy cycles counted in S_WAIT before fe_done is pulsed again.
  localparam logic [1:0] REPULSE_LAST = 2'd3;

  function automatic logic cmd_legal(input logic [7:0] code, input logic [7:0] cmd_max);
    return (code != CMD_NONE) && (code <= cmd_max);
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_timer.sv
// Saturating up-counter with synchronous clear and enable; hit flags the
// cycle in which the count equals the terminal value.
module cmd_timeout_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frame hunter and command sequencer between the UART receiver and
// fifo_control: validates HDR/CMD/LEN_H/LEN_L/CHK frames and runs the handshake.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter logic [15:0] BYTE_TO = 16'd50000,
  parameter logic [31:0] RUN_TO  = 32'd500000000,
  parameter logic [7:0]  CMD_MAX = 8'h04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ok,
  input  logic        fifo_busy,
  input  logic        fifo_done,
  output logic [7:0]  cmd,
  output logic [15:0] rx_cnt,
  output logic        fe_done,
  output logic        err_chk,
  output logic        err_cmd,
  output logic        err_to,
  output logic        seq_busy,
  output state_t      dbg_state
);

  localparam logic [15:0] BYTE_TERM = BYTE_TO - 16'd1;
  localparam logic [31:0] RUN_TERM  = RUN_TO - 32'd1;

  state_t      state, state_n;
  logic        rx_ok_q;
  logic        acc, in_frame;
  logic [7:0]  cmd_lat, cmd_lat_n;
  logic [15:0] len_lat, len_lat_n;
  logic [7:0]  chk_acc, chk_acc_n;
  logic [1:0]  wait_cnt, wait_cnt_n;
  logic [7:0]  cmd_n;
  logic [15:0] rx_cnt_n;
  logic        fe_done_n, err_chk_n, err_cmd_n, err_to_n;
  logic        byte_hit, run_hit;

  assign acc       = rx_ok & ~rx_ok_q;
  assign in_frame  = state inside {S_CMD, S_LENH, S_LENL, S_CHK};
  assign dbg_state = state;

  cmd_timeout_ctr #(.W(16)) u_byte_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc | ~in_frame),
    .en   (in_frame),
    .term (BYTE_TERM),
    .hit  (byte_hit)
  );

  cmd_timeout_ctr #(.W(32)) u_run_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != S_RUN),
    .en   (state == S_RUN),
    .term (RUN_TERM),
    .hit  (run_hit)
  );

  // Handshake: a nonzero cmd is an offer held stable until fifo_busy is
  // sampled high (accept); cmd then returns to CMD_NONE on the next cycle.
  always_comb begin
    state_n    = state;
    cmd_lat_n  = cmd_lat;
    len_lat_n  = len_lat;
    chk_acc_n  = chk_acc;
    wait_cnt_n = '0;
    cmd_n      = cmd;
    rx_cnt_n   = rx_cnt;
    fe_done_n  = 1'b0;
    err_chk_n  = 1'b0;
    err_cmd_n  = 1'b0;
    err_to_n   = 1'b0;

    unique case (state)
      S_HUNT: begin
        if (acc && (rx_data == HDR)) begin
          chk_acc_n = '0;
          state_n   = S_CMD;
        end
      end
      S_CMD: begin
        if (acc) begin
          cmd_lat_n = rx_data;
          chk_acc_n = chk_acc ^ rx_data;
          state_n   = S_LENH;
        end
      end
      S_LENH: begin
        if (acc) begin
          len_lat_n[15:8] = rx_data;
          chk_acc_n       = chk_acc ^ rx_data;
          state_n         = S_LENL;
        end
      end
      S_LENL: begin
        if (acc) begin
          len_lat_n[7:0] = rx_data;
          chk_acc_n      = chk_acc ^ rx_data;
          state_n        = S_CHK;
        end
      end
      S_CHK: begin
        if (acc) begin
          if (chk_acc != rx_data) begin
            err_chk_n = 1'b1;
            state_n   = S_HUNT;
          end else if (!cmd_legal(cmd_lat, CMD_MAX)) begin
            err_cmd_n = 1'b1;
            state_n   = S_HUNT;
          end else begin
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // A still-busy fifo_control must go idle before a new offer is made.
        if (cmd == CMD_NONE) begin
          if (!fifo_busy) begin
            cmd_n    = cmd_lat;
            rx_cnt_n = len_lat;
          end
        end else if (fifo_busy) begin
          cmd_n   = CMD_NONE;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (fifo_done) begin
          state_n = S_REL;
        end else if (run_hit) begin
          err_to_n = 1'b1;
          state_n  = S_REL;
        end
      end
      S_REL: begin
        fe_done_n = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (!fifo_busy) begin
          state_n = S_HUNT;
        end else if (wait_cnt == REPULSE_LAST) begin
          fe_done_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 2'd1;
        end
      end
      default: state_n = S_HUNT;
    endcase

    // Silence between frame bytes; a byte arriving in the same cycle wins.
    if (in_frame && !acc && byte_hit) begin
      err_to_n = 1'b1;
      state_n  = S_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HUNT;
      rx_ok_q  <= 1'b0;
      cmd_lat  <= '0;
      len_lat  <= '0;
      chk_acc  <= '0;
      wait_cnt <= '0;
      cmd      <= CMD_NONE;
      rx_cnt   <= '0;
      fe_done  <= 1'b0;
      err_chk  <= 1'b0;
      err_cmd  <= 1'b0;
      err_to   <= 1'b0;
      seq_busy <= 1'b0;
    end else begin
      state    <= state_n;
      rx_ok_q  <= rx_ok;
      cmd_lat  <= cmd_lat_n;
      len_lat  <= len_lat_n;
      chk_acc  <= chk_acc_n;
      wait_cnt <= wait_cnt_n;
      cmd      <= cmd_n;
      rx_cnt   <= rx_cnt_n;
      fe_done  <= fe_done_n;
      err_chk  <= err_chk_n;
      err_cmd  <= err_cmd_n;
      err_to   <= err_to_n;
      seq_busy <= (state_n != S_HUNT);
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed and randomized bench for uart_cmd_sequencer against a frame-level
// reference model with an expected-issue queue.
module tb_uart_cmd_sequencer;
  import uart_cmd_pkg::*;

  localparam logic [7:0]  HDR_T     = 8'hA5;
  localparam logic [15:0] BYTE_TO_T = 16'd40;
  localparam logic [31:0] RUN_TO_T  = 32'd100;
  localparam logic [7:0]  CMD_MAX_T = 8'h04;
  localparam int W = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ok, fifo_busy, fifo_done;
  logic [7:0]  cmd;
  logic [15:0] rx_cnt;
  logic        fe_done, err_chk, err_cmd, err_to, seq_busy;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  int n_chk = 0, n_cmd = 0, n_to = 0, n_fe = 0;
  int exp_chk = 0, exp_cmd = 0, exp_to = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] cmd_prev = 8'h00;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(
    .HDR(HDR_T), .BYTE_TO(BYTE_TO_T), .RUN_TO(RUN_TO_T), .CMD_MAX(CMD_MAX_T)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ok(rx_ok),
    .fifo_busy(fifo_busy), .fifo_done(fifo_done), .cmd(cmd), .rx_cnt(rx_cnt),
    .fe_done(fe_done), .err_chk(err_chk), .err_cmd(err_cmd), .err_to(err_to),
    .seq_busy(seq_busy), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pulse high-cycle counts and scoreboard of issued commands.
  always @(negedge clk) begin
    if (err_chk) n_chk++;
    if (err_cmd) n_cmd++;
    if (err_to)  n_to++;
    if (fe_done) n_fe++;
    if ((cmd != 8'h00) && (cmd_prev == 8'h00)) begin
      if (exp_q.size() == 0) check("unexpected_issue", {8'h00, cmd, rx_cnt}, 32'h0);
      else check("issue", {8'h00, cmd, rx_cnt}, {8'h00, exp_q.pop_front()});
    end
    cmd_prev = cmd;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference rule: 0 = issue, 1 = checksum error, 2 = illegal command.
  function automatic int frame_outcome(input logic [7:0] c, lh, ll, ck);
    if ((c ^ lh ^ ll) != ck) return 1;
    if ((c == 8'h00) || (c > CMD_MAX_T)) return 2;
    return 0;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data = b;
    rx_ok   = 1'b1;
    repeat (hold) tick();
    rx_ok = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] c, lh, ll, ck, input int max_gap);
    logic [7:0] fr [5];
    int o;
    fr = '{HDR_T, c, lh, ll, ck};
    o = frame_outcome(c, lh, ll, ck);
    if (o == 0) exp_q.push_back({c, lh, ll});
    else if (o == 1) exp_chk++;
    else exp_cmd++;
    for (int i = 0; i < 5; i++) begin
      send_byte(fr[i], 1);
      repeat ($urandom_range(max_gap, 0)) tick();
    end
  endtask

  // Plays fifo_control: accept, run, finish, wait for release.
  task automatic complete_run(input int delay, input int run_len);
    int k;
    repeat (delay) tick();
    fifo_busy = 1'b1;
    k = 0;
    while ((cmd != 8'h00) && (k < 20)) begin tick(); k++; end
    check("cmd_cleared", cmd, 0);
    repeat (run_len) tick();
    fifo_done = 1'b1;
    k = 0;
    while (!fe_done && (k < 20)) begin tick(); k++; end
    check("fe_done_seen", fe_done, 1);
    fifo_done = 1'b0;
    fifo_busy = 1'b0;
    tick();
    tick();
    check("back_to_hunt", seq_busy, 0);
  endtask

  initial begin
    logic [7:0]  c, ck, nb;
    logic [15:0] l;
    int kind;

    rst = 1'b1; rx_data = 8'h00; rx_ok = 1'b0; fifo_busy = 1'b0; fifo_done = 1'b0;
    repeat (3) tick();
    check("rst_cmd", cmd, 0);
    check("rst_rx_cnt", rx_cnt, 0);
    check("rst_flags", {fe_done, err_chk, err_cmd, err_to, seq_busy}, 0);
    check("rst_state", dbg_state, S_HUNT);
    rst = 1'b0;
    tick();

    // Good frame with latency and handshake checks.
    exp_q.push_back({CMD_RX, 16'h0003});
    send_byte(HDR_T, 1); send_byte(CMD_RX, 1); send_byte(8'h00, 1); send_byte(8'h03, 1);
    rx_data = 8'h02; rx_ok = 1'b1; tick();
    check("lat_cmd_early", cmd, 0);
    check("lat_state_issue", dbg_state, S_ISSUE);
    rx_ok = 1'b0; tick();
    check("lat_cmd", cmd, CMD_RX);
    check("lat_rx_cnt", rx_cnt, 16'h0003);
    tick(); tick();
    check("cmd_hold", {cmd, rx_cnt}, {CMD_RX, 16'h0003});
    fifo_busy = 1'b1; tick();
    check("cmd_clear", cmd, 0);
    check("rx_cnt_held", rx_cnt, 16'h0003);
    check("state_run", dbg_state, S_RUN);
    repeat (5) tick();
    fifo_done = 1'b1; tick();
    check("fe_not_yet", fe_done, 0);
    tick();
    check("fe_pulse", fe_done, 1);
    fifo_done = 1'b0; fifo_busy = 1'b0; tick();
    check("fe_one_cycle", fe_done, 0);
    check("idle_after_run", seq_busy, 0);
    check("fe_count", n_fe, 1);
    check("no_errors_yet", n_chk + n_cmd + n_to, 0);

    // Bad checksum, then a good frame.
    send_frame(CMD_INIT, 8'h00, 8'h10, 8'hFF, 0);
    check("bad_chk_count", n_chk, exp_chk);
    check("bad_chk_no_cmd", cmd, 0);
    send_frame(CMD_INIT, 8'h12, 8'h34, 8'h24, 0);
    complete_run(1, 3);

    // Noise, illegal command, and both checks failing.
    send_byte(8'h11, 1); send_byte(8'h22, 1);
    send_frame(8'h07, 8'h00, 8'h00, 8'h07, 0);
    check("bad_cmd_count", n_cmd, exp_cmd);
    check("noise_no_chk", n_chk, exp_chk);
    send_frame(8'h00, 8'h00, 8'h00, 8'h05, 0);
    check("both_bad_chk", n_chk, exp_chk);
    check("both_bad_cmd", n_cmd, exp_cmd);
    check("both_bad_no_cmd", cmd, 0);

    // Byte timeout.
    send_byte(HDR_T, 1); send_byte(CMD_RD, 1);
    repeat (int'(BYTE_TO_T) - 2) tick();
    check("byte_to_early", err_to, 0);
    check("byte_to_wait_state", dbg_state, S_LENH);
    tick();
    exp_to++;
    check("byte_to_pulse", err_to, 1);
    check("byte_to_hunt", dbg_state, S_HUNT);
    tick();
    check("byte_to_count", n_to, exp_to);

    // Byte landing exactly on the timeout cycle is accepted.
    send_byte(HDR_T, 1); send_byte(CMD_RD, 1);
    repeat (int'(BYTE_TO_T) - 2) tick();
    exp_q.push_back({CMD_RD, 16'h0000});
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h03, 1);
    check("edge_acc_no_to", n_to, exp_to);
    complete_run(0, 2);

    // Run timeout with fe_done re-pulsing while busy stays high.
    send_frame(CMD_RX, 8'h00, 8'h05, 8'h04, 0);
    fifo_busy = 1'b1;
    repeat (int'(RUN_TO_T)) tick();
    check("run_to_early", err_to, 0);
    tick();
    exp_to++;
    check("run_to_pulse", err_to, 1);
    check("run_to_fe_not_yet", fe_done, 0);
    tick();
    check("run_to_fe", fe_done, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("fe_repulse", fe_done, ((k % 4) == 0));
    end
    fifo_busy = 1'b0; tick(); tick();
    check("run_to_idle", seq_busy, 0);
    check("run_to_count", n_to, exp_to);

    // fifo_control still busy when the frame completes.
    fifo_busy = 1'b1;
    send_frame(CMD_INIT, 8'h00, 8'h07, 8'h05, 0);
    check("busy_entry_hold", cmd, 0);
    tick(); tick();
    check("busy_entry_hold2", cmd, 0);
    check("busy_entry_state", dbg_state, S_ISSUE);
    fifo_busy = 1'b0; tick();
    check("busy_entry_drive", cmd, CMD_INIT);
    complete_run(0, 1);

    // rx_ok held high for several clocks counts as one byte each.
    exp_q.push_back({CMD_WR, 16'h0001});
    send_byte(HDR_T, 3); send_byte(CMD_WR, 2); send_byte(8'h00, 2); send_byte(8'h01, 2);
    send_byte(8'h05, 2);
    check("long_hold_cmd", cmd, CMD_WR);
    check("long_hold_len", rx_cnt, 16'h0001);
    complete_run(2, 4);

    // Reset during S_RUN aborts silently.
    send_frame(CMD_RD, 8'h01, 8'h00, 8'h02, 0);
    fifo_busy = 1'b1; tick(); tick();
    check("pre_rst_state", dbg_state, S_RUN);
    check("pre_rst_len", rx_cnt, 16'h0100);
    rst = 1'b1; tick();
    check("rst_run_outputs", {cmd, rx_cnt, fe_done, err_chk, err_cmd, err_to, seq_busy}, 0);
    check("rst_run_state", dbg_state, S_HUNT);
    rst = 1'b0; fifo_busy = 1'b0;
    repeat (3) tick();
    check("rst_run_no_err", {n_chk, n_cmd, n_to}, {exp_chk, exp_cmd, exp_to});

    // Randomized frames against the reference rule.
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(3, 1)) begin
          nb = 8'($urandom_range(255, 0));
          if (nb == HDR_T) nb = 8'h5A;
          send_byte(nb, 1);
        end
      end
      kind = $urandom_range(3, 0);
      l = 16'($urandom_range(65535, 0));
      c = 8'($urandom_range(4, 1));
      if (kind == 3) c = ($urandom_range(1, 0) == 1) ? 8'h00 : 8'($urandom_range(255, 5));
      ck = c ^ l[15:8] ^ l[7:0];
      if (kind == 2) ck = ck ^ 8'($urandom_range(255, 1));
      send_frame(c, l[15:8], l[7:0], ck, 3);
      if (frame_outcome(c, l[15:8], l[7:0], ck) == 0)
        complete_run($urandom_range(3, 0), $urandom_range(10, 0));
    end
    tick();
    check("rand_chk_count", n_chk, exp_chk);
    check("rand_cmd_count", n_cmd, exp_cmd);
    check("rand_to_count", n_to, exp_to);
    check("rand_exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
